// File: rtl/sal_axi_rw_sched_pkg.sv
// Shared types for the AXI read/write request scheduler.
// AXI widths normally come from SAL_DDR_PARAMS.svh; the defaults below apply when that header is absent.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

package sal_sched_pkg;
    localparam int ID_W   = `AXI_ID_WIDTH;
    localparam int ADDR_W = `AXI_ADDR_WIDTH;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {IDLE, RD, WR, TURN} sched_state_t;

    typedef struct packed {
        logic              wr;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } sched_req_t;

    function automatic sched_state_t dir_state(input logic wr);
        return wr ? WR : RD;
    endfunction
endpackage

// File: rtl/sal_axi_rw_sched_if.sv
// AXI AR/AW address channels plus the scheduled request channel toward the request queue.
interface sal_axi_rw_sched_if;
    import sal_sched_pkg::*;

    logic              ar_valid;
    logic              ar_ready;
    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_len;
    logic              aw_valid;
    logic              aw_ready;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [LEN_W-1:0]  aw_len;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ID_W-1:0]   req_id;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    // Scheduler side: accepts AXI addresses, produces scheduled requests.
    modport slave (
        input  ar_valid, ar_id, ar_addr, ar_len,
        input  aw_valid, aw_id, aw_addr, aw_len,
        input  req_ready,
        output ar_ready, aw_ready,
        output req_valid, req_wr, req_id, req_addr, req_len
    );

    modport master (
        output ar_valid, ar_id, ar_addr, ar_len,
        output aw_valid, aw_id, aw_addr, aw_len,
        output req_ready,
        input  ar_ready, aw_ready,
        input  req_valid, req_wr, req_id, req_addr, req_len
    );
endinterface

// File: rtl/sal_axi_rw_sched.sv
// Merges AXI AR/AW into one request stream, batching same-direction grants with a turnaround gap.
// Optional statistics counters are enabled by defining SAL_RW_SCHED_STAT_EN.
module sal_axi_rw_sched
    import sal_sched_pkg::*;
#(
    parameter int MAX_BATCH   = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sal_axi_rw_sched_if.slave       bus
`ifdef SAL_RW_SCHED_STAT_EN
    ,
    output logic [31:0]             stat_rd_cnt,
    output logic [31:0]             stat_wr_cnt,
    output logic [31:0]             stat_turn_cnt
`endif
);
    localparam int BW = $clog2(MAX_BATCH + 1);
    localparam int TW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BATCH_LAST = BW'(MAX_BATCH - 1);
    localparam logic [TW-1:0] TURN_LAST  = (TURN_CYCLES > 0) ? TW'(TURN_CYCLES - 1) : '0;

    sched_state_t   state_reg;
    logic           target_wr_reg;
    logic [BW-1:0]  batch_cnt_reg;
    logic [TW-1:0]  turn_cnt_reg;
    logic           req_valid_reg;
    sched_req_t     req_reg;

    logic           slot_free;
    logic           rd_grant;
    logic           wr_grant;
    logic           batch_last;
    logic           switch_req;
    logic           switch_to_wr;
    sched_req_t     req_next;

    always_comb begin
        slot_free    = !req_valid_reg || bus.req_ready;
        rd_grant     = (state_reg == RD) && slot_free && bus.ar_valid;
        wr_grant     = (state_reg == WR) && slot_free && bus.aw_valid;
        batch_last   = (batch_cnt_reg == BATCH_LAST);
        switch_req   = 1'b0;
        switch_to_wr = 1'b0;
        // Leave a direction when its batch is exhausted, or when it goes quiet while the other side waits.
        case (state_reg)
            RD: begin
                if ((rd_grant && batch_last && bus.aw_valid) || (!bus.ar_valid && bus.aw_valid)) begin
                    switch_req   = 1'b1;
                    switch_to_wr = 1'b1;
                end
            end
            WR: begin
                if ((wr_grant && batch_last && bus.ar_valid) || (!bus.aw_valid && bus.ar_valid)) begin
                    switch_req   = 1'b1;
                end
            end
            default: ;
        endcase
        req_next = rd_grant ? {1'b0, bus.ar_id, bus.ar_addr, bus.ar_len}
                            : {1'b1, bus.aw_id, bus.aw_addr, bus.aw_len};
    end

    assign bus.ar_ready  = (state_reg == RD) && slot_free;
    assign bus.aw_ready  = (state_reg == WR) && slot_free;
    assign bus.req_valid = req_valid_reg;
    assign bus.req_wr    = req_reg.wr;
    assign bus.req_id    = req_reg.id;
    assign bus.req_addr  = req_reg.addr;
    assign bus.req_len   = req_reg.len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            target_wr_reg <= 1'b0;
            batch_cnt_reg <= '0;
            turn_cnt_reg  <= '0;
            req_valid_reg <= 1'b0;
            req_reg       <= '0;
        end else begin
            if (rd_grant || wr_grant) begin
                req_valid_reg <= 1'b1;
                req_reg       <= req_next;
            end else if (bus.req_ready) begin
                req_valid_reg <= 1'b0;
            end

            if (switch_req) begin
                batch_cnt_reg <= '0;
                turn_cnt_reg  <= '0;
                target_wr_reg <= switch_to_wr;
                state_reg     <= (TURN_CYCLES == 0) ? dir_state(switch_to_wr) : TURN;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.ar_valid)      state_reg <= RD;
                        else if (bus.aw_valid) state_reg <= WR;
                    end
                    RD, WR: begin
                        // Batch limit with the other side idle simply wraps and keeps the direction.
                        if (rd_grant || wr_grant)
                            batch_cnt_reg <= batch_last ? '0 : batch_cnt_reg + BW'(1);
                    end
                    TURN: begin
                        if (turn_cnt_reg == TURN_LAST) begin
                            turn_cnt_reg <= '0;
                            state_reg    <= dir_state(target_wr_reg);
                        end else begin
                            turn_cnt_reg <= turn_cnt_reg + TW'(1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

`ifdef SAL_RW_SCHED_STAT_EN
    logic [31:0] stat_rd_cnt_reg;
    logic [31:0] stat_wr_cnt_reg;
    logic [31:0] stat_turn_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_cnt_reg   <= '0;
            stat_wr_cnt_reg   <= '0;
            stat_turn_cnt_reg <= '0;
        end else begin
            if (rd_grant)   stat_rd_cnt_reg   <= stat_rd_cnt_reg + 32'd1;
            if (wr_grant)   stat_wr_cnt_reg   <= stat_wr_cnt_reg + 32'd1;
            if (switch_req) stat_turn_cnt_reg <= stat_turn_cnt_reg + 32'd1;
        end
    end

    assign stat_rd_cnt   = stat_rd_cnt_reg;
    assign stat_wr_cnt   = stat_wr_cnt_reg;
    assign stat_turn_cnt = stat_turn_cnt_reg;
`endif
endmodule

// File: tb/tb_sal_axi_rw_sched.sv
// Directed bench for sal_axi_rw_sched: grant ordering, batching, turnaround, backpressure and reset.
module tb_sal_axi_rw_sched;
    import sal_sched_pkg::*;

    localparam int MAX_BATCH   = 8;
    localparam int TURN_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sal_axi_rw_sched_if bus();

`ifdef SAL_RW_SCHED_STAT_EN
    logic [31:0] stat_rd_cnt, stat_wr_cnt, stat_turn_cnt;
`endif

    sal_axi_rw_sched #(.MAX_BATCH(MAX_BATCH), .TURN_CYCLES(TURN_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef SAL_RW_SCHED_STAT_EN
        ,
        .stat_rd_cnt   (stat_rd_cnt),
        .stat_wr_cnt   (stat_wr_cnt),
        .stat_turn_cnt (stat_turn_cnt)
`endif
    );

    always #5 clk = ~clk;

    sched_req_t ar_q[$];
    sched_req_t aw_q[$];
    sched_req_t out_q[$];

    int          cyc, n_grant, n_wr_grant, last_grant_cyc, first_valid_cyc, both_low;
    logic [31:0] seq;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    logic              s_req_valid, s_ar_ready;
    logic [ID_W-1:0]   s_req_id;
    logic [ADDR_W-1:0] s_req_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic sched_req_t mk(input bit wr, input int id, input int addr, input int len);
        sched_req_t r;
        r.wr   = wr;
        r.id   = ID_W'(id);
        r.addr = ADDR_W'(addr);
        r.len  = LEN_W'(len);
        return r;
    endfunction

    task automatic drive_inputs();
        bus.ar_valid = (ar_q.size() > 0);
        if (ar_q.size() > 0) begin
            bus.ar_id = ar_q[0].id; bus.ar_addr = ar_q[0].addr; bus.ar_len = ar_q[0].len;
        end
        bus.aw_valid = (aw_q.size() > 0);
        if (aw_q.size() > 0) begin
            bus.aw_id = aw_q[0].id; bus.aw_addr = aw_q[0].addr; bus.aw_len = aw_q[0].len;
        end
    endtask

    task automatic clear_logs();
        cyc = 0; n_grant = 0; n_wr_grant = 0; last_grant_cyc = -1;
        first_valid_cyc = -1; both_low = 0; seq = '0;
        out_q.delete();
    endtask

    // One clock: sample at the falling edge, log handshakes, then update inputs after the rising edge.
    task automatic tick();
        logic ar_hs, aw_hs, out_hs;
        sched_req_t r;
        @(negedge clk);
        s_req_valid = bus.req_valid;
        s_ar_ready  = bus.ar_ready;
        s_req_id    = bus.req_id;
        s_req_addr  = bus.req_addr;
        ar_hs  = bus.ar_valid && bus.ar_ready;
        aw_hs  = bus.aw_valid && bus.aw_ready;
        out_hs = bus.req_valid && bus.req_ready;
        if (n_grant > 0 && !bus.ar_ready && !bus.aw_ready) both_low++;
        if (ar_hs) begin n_grant++; last_grant_cyc = cyc; seq = {seq[30:0], 1'b0}; end
        if (aw_hs) begin n_grant++; n_wr_grant++; last_grant_cyc = cyc; seq = {seq[30:0], 1'b1}; end
        if (bus.req_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_hs) begin
            r.wr = bus.req_wr; r.id = bus.req_id; r.addr = bus.req_addr; r.len = bus.req_len;
            out_q.push_back(r);
            $display("cyc %0d req wr=%0d id=0x%0h addr=0x%0h len=%0d", cyc, r.wr, r.id, r.addr, r.len);
        end
        @(posedge clk);
        #1;
        if (ar_hs) void'(ar_q.pop_front());
        if (aw_hs) void'(aw_q.pop_front());
        drive_inputs();
        cyc++;
    endtask

    task automatic run_until_done(input int bound);
        int n = 0;
        while ((ar_q.size() > 0 || aw_q.size() > 0 || bus.req_valid) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) check_eq("timeout", 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ar_q.delete();
        aw_q.delete();
        bus.ar_valid = 1'b0;
        bus.aw_valid = 1'b0;
        bus.req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
        bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
        bus.req_ready = 1'b1;
        clear_logs();

        // Reset state
        #12;
        check_eq("rst_req_valid", 64'(bus.req_valid), 64'd0);
        check_eq("rst_ar_ready",  64'(bus.ar_ready),  64'd0);
        check_eq("rst_aw_ready",  64'(bus.aw_ready),  64'd0);
        check_eq("rst_req_addr",  64'(bus.req_addr),  64'd0);

        // 1: single read from IDLE, visible two cycles after ar_valid
        do_reset();
        ar_q.push_back(mk(0, 0, 32'h0, 1));
        drive_inputs();
        run_until_done(50);
        check_eq("s1_first_valid", 64'(first_valid_cyc), 64'd2);
        check_eq("s1_count",       64'(out_q.size()),    64'd1);
        check_eq("s1_grants",      64'(n_grant),         64'd1);
        check_eq("s1_wr",          64'(out_q[0].wr),     64'd0);
        check_eq("s1_addr",        64'(out_q[0].addr),   64'h0);
        check_eq("s1_len",         64'(out_q[0].len),    64'd1);

        // 2: AR and AW together -> read, two-cycle turn, write
        do_reset();
        ar_q.push_back(mk(0, 1, 32'h100, 3));
        aw_q.push_back(mk(1, 2, 32'h200, 7));
        drive_inputs();
        run_until_done(50);
        check_eq("s2_order",      64'(seq[1:0]),       64'h1);
        check_eq("s2_grants",     64'(n_grant),        64'd2);
        check_eq("s2_wr_cycle",   64'(last_grant_cyc), 64'd5);
        check_eq("s2_both_low",   64'(both_low),       64'd2);
        check_eq("s2_wr_addr",    64'(out_q[1].addr),  64'h200);
        check_eq("s2_wr_flag",    64'(out_q[1].wr),    64'd1);

        // 3: 12 reads with one write pending -> 8R, TURN, W, TURN, 4R
        do_reset();
        for (int i = 0; i < 12; i++) ar_q.push_back(mk(0, i, i * 32'h40, 0));
        aw_q.push_back(mk(1, 5, 32'h800, 2));
        drive_inputs();
        run_until_done(100);
        check_eq("s3_grants",    64'(n_grant),        64'd13);
        check_eq("s3_wr_grants", 64'(n_wr_grant),     64'd1);
        check_eq("s3_seq",       64'(seq[12:0]),      64'h010);
        check_eq("s3_last_cyc",  64'(last_grant_cyc), 64'd18);
        check_eq("s3_both_low",  64'(both_low),       64'd4);
        check_eq("s3_wr_id",     64'(out_q[8].id),    64'd5);
        check_eq("s3_wr_pos",    64'(out_q[8].wr),    64'd1);
        check_eq("s3_last_addr", 64'(out_q[12].addr), 64'h2C0);

        // 4: entry held under backpressure for five cycles
        do_reset();
        bus.req_ready = 1'b0;
        ar_q.push_back(mk(0, 'hA, 32'h1000, 4));
        ar_q.push_back(mk(0, 'hB, 32'h2000, 5));
        drive_inputs();
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq($sformatf("s4_hold_valid%0d", k), 64'(s_req_valid), 64'd1);
            check_eq($sformatf("s4_hold_addr%0d", k),  64'(s_req_addr),  64'h1000);
            check_eq($sformatf("s4_hold_id%0d", k),    64'(s_req_id),    64'hA);
            check_eq($sformatf("s4_ar_ready%0d", k),   64'(s_ar_ready),  64'd0);
        end
        bus.req_ready = 1'b1;
        run_until_done(50);
        check_eq("s4_count",     64'(out_q.size()),   64'd2);
        check_eq("s4_id0",       64'(out_q[0].id),    64'hA);
        check_eq("s4_id1",       64'(out_q[1].id),    64'hB);
        check_eq("s4_grant2cyc", 64'(last_grant_cyc), 64'd7);

        // 5: reads only -> batch wraps, no turnaround, no bubbles
        do_reset();
        for (int i = 0; i < 20; i++) ar_q.push_back(mk(0, i % 16, i * 32'h10, 0));
        drive_inputs();
        run_until_done(100);
        check_eq("s5_grants",    64'(n_grant),        64'd20);
        check_eq("s5_wr_grants", 64'(n_wr_grant),     64'd0);
        check_eq("s5_last_cyc",  64'(last_grant_cyc), 64'd20);
        check_eq("s5_both_low",  64'(both_low),       64'd0);
        check_eq("s5_count",     64'(out_q.size()),   64'd20);
        check_eq("s5_last_addr", 64'(out_q[19].addr), 64'h130);

        // 6: asynchronous reset in the middle of TURN with an entry held
        do_reset();
        bus.req_ready = 1'b0;
        ar_q.push_back(mk(0, 3, 32'h300, 1));
        aw_q.push_back(mk(1, 4, 32'h400, 1));
        drive_inputs();
        tick();
        tick();
        tick();
        check_eq("s6_pre_valid", 64'(bus.req_valid), 64'd1);
        check_eq("s6_in_turn",   64'(bus.ar_ready | bus.aw_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("s6_req_valid", 64'(bus.req_valid), 64'd0);
        check_eq("s6_ar_ready",  64'(bus.ar_ready),  64'd0);
        check_eq("s6_aw_ready",  64'(bus.aw_ready),  64'd0);
        check_eq("s6_req_wr",    64'(bus.req_wr),    64'd0);
        check_eq("s6_req_id",    64'(bus.req_id),    64'd0);
        check_eq("s6_req_addr",  64'(bus.req_addr),  64'd0);
        check_eq("s6_req_len",   64'(bus.req_len),   64'd0);
`ifdef SAL_RW_SCHED_STAT_EN
        check_eq("s6_stat_rd",   64'(stat_rd_cnt),   64'd0);
        check_eq("s6_stat_wr",   64'(stat_wr_cnt),   64'd0);
        check_eq("s6_stat_turn", 64'(stat_turn_cnt), 64'd0);
`endif
        do_reset();
        ar_q.push_back(mk(0, 0, 32'h0, 1));
        drive_inputs();
        run_until_done(50);
        check_eq("s6_first_valid", 64'(first_valid_cyc), 64'd2);
        check_eq("s6_count",       64'(out_q.size()),    64'd1);
        check_eq("s6_addr",        64'(out_q[0].addr),   64'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
